// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: owns the PC and tracks which fetched word is on the imem output.
// Optional PC range check is enabled by defining PC_BOUND_CHECK_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RUN  | fetching: advance, stall, or redirect the PC
// ST_HALT | fetch stopped; only reset leaves this state
module fetch_pc_unit #(
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] RESET_PC   = '0,
   parameter int              IMEM_DEPTH = 11
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_stall,
   input  logic            in_redirect,
   input  logic [PC_W-1:0] in_target,
   input  logic            in_halt,
   output logic [PC_W-1:0] out_pc,
   output logic [PC_W-1:0] out_inst_pc,
   output logic            out_inst_valid,
   output logic            out_halted,
   output logic [31:0]     out_fetch_count,
   output logic            out_fault
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] inst_pc_q, inst_pc_d;
   logic            inst_valid_q, inst_valid_d;
   logic [31:0]     count_q, count_d;
   logic [PC_W-1:0] next_pc;
   logic            load_pc;

`ifdef PC_BOUND_CHECK_EN
   localparam logic [PC_W-1:0] DEPTH_LIM = PC_W'(IMEM_DEPTH);
   logic            fault_q, fault_d;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      count_d      = count_q;
      next_pc      = pc_q + PC_W'(1);
      load_pc      = 1'b0;
`ifdef PC_BOUND_CHECK_EN
      fault_d      = fault_q;
`endif

      // A valid word is consumed whenever decode is not stalling us.
      if (state_q == ST_RUN && inst_valid_q && !in_stall) begin
         count_d = count_q + 32'd1;
      end

      if (state_q == ST_HALT) begin
         inst_valid_d = 1'b0;
      end else if (in_halt) begin
         state_d      = ST_HALT;
         inst_valid_d = 1'b0;
      end else if (in_redirect) begin
         // The word sampled at this edge is wrong-path: report it, but squashed.
         next_pc      = in_target;
         load_pc      = 1'b1;
         inst_pc_d    = pc_q;
         inst_valid_d = 1'b0;
      end else if (!in_stall) begin
         load_pc      = 1'b1;
         inst_pc_d    = pc_q;
         inst_valid_d = 1'b1;
      end

      if (load_pc) begin
`ifdef PC_BOUND_CHECK_EN
         if (next_pc >= DEPTH_LIM) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
         end else begin
            pc_d = next_pc;
         end
`else
         pc_d = next_pc;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         inst_pc_q    <= RESET_PC;
         inst_valid_q <= 1'b0;
         count_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         count_q      <= count_d;
      end
   end

`ifdef PC_BOUND_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
   assign out_fault = fault_q;
`else
   assign out_fault = 1'b0;
`endif

   assign out_pc          = pc_q;
   assign out_inst_pc     = inst_pc_q;
   assign out_inst_valid  = inst_valid_q;
   assign out_halted      = (state_q == ST_HALT);
   assign out_fetch_count = count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit; extra range-check sequence when PC_BOUND_CHECK_EN is defined.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_stall;
   logic        in_redirect;
   logic [31:0] in_target;
   logic        in_halt;
   logic [31:0] out_pc;
   logic [31:0] out_inst_pc;
   logic        out_inst_valid;
   logic        out_halted;
   logic [31:0] out_fetch_count;
   logic        out_fault;

   int total = 0;
   int bad   = 0;

   fetch_pc_unit #(.PC_W(32), .RESET_PC(32'd0), .IMEM_DEPTH(11)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_stall       (in_stall),
      .in_redirect    (in_redirect),
      .in_target      (in_target),
      .in_halt        (in_halt),
      .out_pc         (out_pc),
      .out_inst_pc    (out_inst_pc),
      .out_inst_valid (out_inst_valid),
      .out_halted     (out_halted),
      .out_fetch_count(out_fetch_count),
      .out_fault      (out_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        redir;
      logic        halt;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      logic [31:0] e_ipc;
      logic        e_v;
      logic        e_h;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic h,
                               input logic [31:0] t, input logic [31:0] pc,
                               input logic [31:0] ipc, input logic v, input logic hd,
                               input logic [31:0] cnt);
      vec_t x;
      x.rst_n = r;  x.stall = s;  x.redir = rd; x.halt = h; x.tgt = t;
      x.e_pc  = pc; x.e_ipc = ipc; x.e_v = v;   x.e_h = hd; x.e_cnt = cnt;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic rd, input logic h,
                       input logic [31:0] t);
      rst_n = r; in_stall = s; in_redirect = rd; in_halt = h; in_target = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_stall = 1'b0; in_redirect = 1'b0; in_halt = 1'b0; in_target = '0;

      //               rst stl rd hlt tgt            pc            ipc           v  h  cnt
      // reset then free-run
      tbl.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        1, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd3,        32'd2,        1, 0, 32'd2));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd4,        32'd3,        1, 0, 32'd3));
      // stall held three cycles at pc=2
      tbl.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        1, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 1, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 1, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 1, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd3,        32'd2,        1, 0, 32'd2));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd4,        32'd3,        1, 0, 32'd3));
      // redirect to 7 at pc=3, then again with stall in the same cycle
      tbl.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        1, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd3,        32'd2,        1, 0, 32'd2));
      tbl.push_back(mk(1, 0, 1, 0, 32'd7,        32'd7,        32'd3,        0, 0, 32'd3));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd8,        32'd7,        1, 0, 32'd3));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd9,        32'd8,        1, 0, 32'd4));
      tbl.push_back(mk(1, 1, 1, 0, 32'd7,        32'd7,        32'd9,        0, 0, 32'd4));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd8,        32'd7,        1, 0, 32'd4));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd9,        32'd8,        1, 0, 32'd5));
      // halt with redirect at pc=5; HALT ignores later redirect; reset exits
      tbl.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        1, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd2,        32'd1,        1, 0, 32'd1));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd3,        32'd2,        1, 0, 32'd2));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd4,        32'd3,        1, 0, 32'd3));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd5,        32'd4,        1, 0, 32'd4));
      tbl.push_back(mk(1, 0, 1, 1, 32'd2,        32'd5,        32'd4,        0, 1, 32'd5));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd5,        32'd4,        0, 1, 32'd5));
      tbl.push_back(mk(1, 0, 1, 0, 32'd3,        32'd5,        32'd4,        0, 1, 32'd5));
      tbl.push_back(mk(0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0, 0, 32'd0));
      // reset wins over a simultaneous redirect
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        1, 0, 32'd0));
      tbl.push_back(mk(0, 0, 1, 0, 32'd9,        32'd0,        32'd0,        0, 0, 32'd0));
`ifndef PC_BOUND_CHECK_EN
      // PC wraps from all-ones to zero
      tbl.push_back(mk(1, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        0, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd0,        32'hFFFFFFFF, 1, 0, 32'd0));
      tbl.push_back(mk(1, 0, 0, 0, 32'd0,        32'd1,        32'd0,        1, 0, 32'd1));
`endif

      foreach (tbl[i]) begin
         step(tbl[i].rst_n, tbl[i].stall, tbl[i].redir, tbl[i].halt, tbl[i].tgt);
         chk($sformatf("v%0d.pc", i),    out_pc,                  tbl[i].e_pc);
         chk($sformatf("v%0d.ipc", i),   out_inst_pc,             tbl[i].e_ipc);
         chk($sformatf("v%0d.valid", i), {31'd0, out_inst_valid}, {31'd0, tbl[i].e_v});
         chk($sformatf("v%0d.halted", i),{31'd0, out_halted},     {31'd0, tbl[i].e_h});
         chk($sformatf("v%0d.count", i), out_fetch_count,         tbl[i].e_cnt);
         chk($sformatf("v%0d.fault", i), {31'd0, out_fault},      32'd0);
      end

`ifdef PC_BOUND_CHECK_EN
      // Run off the end of an 11-word memory
      step(0, 0, 0, 0, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step(1, 0, 0, 0, 32'd0);
         chk($sformatf("bnd%0d.pc", k),    out_pc,      32'(k));
         chk($sformatf("bnd%0d.ipc", k),   out_inst_pc, 32'(k - 1));
         chk($sformatf("bnd%0d.fault", k), {31'd0, out_fault}, 32'd0);
      end
      step(1, 0, 0, 0, 32'd0);
      chk("bnd_end.pc",     out_pc,                  32'd10);
      chk("bnd_end.ipc",    out_inst_pc,             32'd10);
      chk("bnd_end.valid",  {31'd0, out_inst_valid}, 32'd1);
      chk("bnd_end.fault",  {31'd0, out_fault},      32'd1);
      chk("bnd_end.halted", {31'd0, out_halted},     32'd1);
      step(1, 0, 0, 0, 32'd0);
      chk("bnd_hold.pc",    out_pc,                  32'd10);
      chk("bnd_hold.valid", {31'd0, out_inst_valid}, 32'd0);
      chk("bnd_hold.fault", {31'd0, out_fault},      32'd1);
      // Out-of-range redirect target
      step(0, 0, 0, 0, 32'd0);
      chk("bnd_rst.fault", {31'd0, out_fault}, 32'd0);
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 32'd0);
      chk("bnd_pre.pc", out_pc, 32'd4);
      step(1, 0, 1, 0, 32'd12);
      chk("bnd_rd.pc",     out_pc,                  32'd4);
      chk("bnd_rd.valid",  {31'd0, out_inst_valid}, 32'd0);
      chk("bnd_rd.fault",  {31'd0, out_fault},      32'd1);
      chk("bnd_rd.halted", {31'd0, out_halted},     32'd1);
      step(1, 0, 0, 0, 32'd0);
      chk("bnd_rd2.pc",    out_pc,             32'd4);
      chk("bnd_rd2.fault", {31'd0, out_fault}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
